counter_prog: RTL and testbench

Parametrised programmable counter, the successor to the fixed down-counter in the lab 1 timing blocks. It counts up or down between 0 and a run-time limit, and a prescaler sets its tick rate. It supports synchronous load and three terminal behaviours: wrap, saturate and one-shot. It drives a one-cycle terminal-count pulse that downstream sequencing logic and display blocks use as an event strobe.

---
 rtl/counter_prog_if.sv | 27 ++
 rtl/counter_prog.sv | 107 ++++++++++
 tb/tb_counter_prog.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/counter_prog_if.sv
// Control/status bundle for counter_prog: run-time controls in, count and strobes out.
// The master drives the controls and the slave (the counter) drives result/tc/done.
interface counter_prog_if #(
    parameter int dw = 8,
    parameter int pw = 4
);
    logic          ena;
    logic          load;
    logic [dw-1:0] load_val;
    logic          up;
    logic [1:0]    mode;
    logic [dw-1:0] max_val;
    logic [pw-1:0] prescale;
    logic [dw-1:0] result;
    logic          tc;
    logic          done;

    modport master (
        output ena, load, load_val, up, mode, max_val, prescale,
        input  result, tc, done
    );

    modport slave (
        input  ena, load, load_val, up, mode, max_val, prescale,
        output result, tc, done
    );
endinterface

// File: rtl/counter_prog.sv
// Programmable up/down counter with prescaler, clamped load and wrap/saturate/one-shot
// terminal behaviour; tc is a one-cycle strobe on entry into the terminal value.
module counter_prog #(
    parameter int dw   = 8,
    parameter int pw   = 4,
    parameter int INIT = 7
) (
    input  logic            clk,
    input  logic            reset,
    counter_prog_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_SAT_ALT = 2'b11
    } mode_e;

    localparam logic [dw-1:0] INIT_V = dw'(INIT);

    logic [dw-1:0] result_q, result_d;
    logic [pw-1:0] pc_q, pc_d;
    logic          tc_q, tc_d;
    logic          done_q, done_d;

    mode_e         md;
    logic          is_wrap;
    logic [dw-1:0] next_val;
    logic [dw-1:0] term_val;

    // Increment is gated by the limit compare, so it can never overflow dw bits.
    function automatic logic [dw-1:0] step_up(input logic [dw-1:0] cur,
                                              input logic [dw-1:0] lim,
                                              input logic          wrap);
        if (cur < lim)
            return cur + dw'(1);
        else if (wrap)
            return '0;
        else
            return lim;
    endfunction

    function automatic logic [dw-1:0] step_down(input logic [dw-1:0] cur,
                                                input logic [dw-1:0] lim,
                                                input logic          wrap);
        if (cur != '0)
            return cur - dw'(1);
        else if (wrap)
            return lim;
        else
            return '0;
    endfunction

    function automatic logic [dw-1:0] clamp(input logic [dw-1:0] val,
                                            input logic [dw-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    assign md       = mode_e'(bus.mode);
    assign is_wrap  = (md == MODE_WRAP);
    assign term_val = bus.up ? bus.max_val : '0;
    assign next_val = bus.up ? step_up(result_q, bus.max_val, is_wrap)
                             : step_down(result_q, bus.max_val, is_wrap);

    always_comb begin
        result_d = result_q;
        pc_d     = pc_q;
        done_d   = done_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            result_d = clamp(bus.load_val, bus.max_val);
            pc_d     = '0;
            done_d   = 1'b0;
        end else if (bus.ena && !done_q) begin
            // Exact match only: a pc left above a newly lowered prescale runs on through 2^pw.
            if (pc_q == bus.prescale) begin
                pc_d     = '0;
                result_d = next_val;
                tc_d     = (next_val == term_val) && (next_val != result_q);
                done_d   = tc_d && (md == MODE_ONESHOT);
            end else begin
                pc_d = pc_q + pw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= INIT_V;
            pc_q     <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            pc_q     <= pc_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.tc     = tc_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_counter_prog.sv
// Directed bench for counter_prog: stimulus pushes hand-computed expectations into a
// scoreboard queue and a monitor compares them one cycle-sample after each rising edge.
module tb_counter_prog;

    logic clk;
    logic reset;

    counter_prog_if #(.dw(8), .pw(4)) bus ();

    counter_prog #(.dw(8), .pw(4), .INIT(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] r;
        logic       t;
        logic       d;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t cur_e;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [7:0] ar, input logic at, input logic ad,
                         input logic [7:0] er, input logic et, input logic ed,
                         input string nm);
        checks++;
        if (ar !== er || at !== et || ad !== ed) begin
            failures++;
            $display("FAIL %s: got result=%0d tc=%0d done=%0d, want result=%0d tc=%0d done=%0d",
                     nm, ar, at, ad, er, et, ed);
        end
    endtask

    // Monitor: compares the outputs after every edge for which stimulus queued an expectation.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            cur_e = sb.pop_front();
            check(bus.result, bus.tc, bus.done, cur_e.r, cur_e.t, cur_e.d, cur_e.nm);
        end
    end

    // Inputs are already set; queue the state expected after the next edge, then advance.
    task automatic cyc(input logic [7:0] r, input logic t, input logic d, input string nm);
        exp_t e;
        e.r = r; e.t = t; e.d = d; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.ena      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.up       = 1'b0;
        bus.mode     = 2'b00;
        bus.max_val  = 8'd7;
        bus.prescale = 4'd0;
        #1 reset = 1'b0;
        #1 check(bus.result, bus.tc, bus.done, 8'd7, 1'b0, 1'b0, "reset_state");

        // Default wrap-down run from INIT
        @(posedge clk);
        #3;
        reset   = 1'b1;
        bus.ena = 1'b1;
        for (int i = 6; i >= 1; i--) cyc(8'(i), 1'b0, 1'b0, "wrap_down");
        cyc(8'd0, 1'b1, 1'b0, "wrap_down_tc");
        cyc(8'd7, 1'b0, 1'b0, "wrap_down_reload");
        cyc(8'd6, 1'b0, 1'b0, "wrap_down_again");

        // Asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1 check(bus.result, bus.tc, bus.done, 8'd7, 1'b0, 1'b0, "async_reset");
        bus.ena = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #3;

        // Prescaler with an enable gap
        bus.prescale = 4'd2;
        bus.ena      = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 8'd3;
        cyc(8'd3, 1'b0, 1'b0, "pre_load");
        bus.load = 1'b0;
        cyc(8'd3, 1'b0, 1'b0, "pre_hold1");
        cyc(8'd3, 1'b0, 1'b0, "pre_hold2");
        cyc(8'd2, 1'b0, 1'b0, "pre_tick1");
        cyc(8'd2, 1'b0, 1'b0, "pre_hold3");
        bus.ena = 1'b0;
        for (int i = 0; i < 5; i++) cyc(8'd2, 1'b0, 1'b0, "pre_ena_off");
        bus.ena = 1'b1;
        cyc(8'd2, 1'b0, 1'b0, "pre_resume");
        cyc(8'd1, 1'b0, 1'b0, "pre_tick2");
        cyc(8'd1, 1'b0, 1'b0, "pre_hold4");
        cyc(8'd1, 1'b0, 1'b0, "pre_hold5");
        cyc(8'd0, 1'b1, 1'b0, "pre_tick3_tc");

        // Saturate up
        bus.prescale = 4'd0;
        bus.max_val  = 8'd252;
        bus.up       = 1'b1;
        bus.mode     = 2'b01;
        bus.load     = 1'b1;
        bus.load_val = 8'd250;
        cyc(8'd250, 1'b0, 1'b0, "sat_load");
        bus.load = 1'b0;
        cyc(8'd251, 1'b0, 1'b0, "sat_up");
        cyc(8'd252, 1'b1, 1'b0, "sat_tc");
        cyc(8'd252, 1'b0, 1'b0, "sat_hold1");
        cyc(8'd252, 1'b0, 1'b0, "sat_hold2");

        // One-shot down, then reload clears done
        bus.up       = 1'b0;
        bus.mode     = 2'b10;
        bus.load     = 1'b1;
        bus.load_val = 8'd2;
        cyc(8'd2, 1'b0, 1'b0, "os_load");
        bus.load = 1'b0;
        cyc(8'd1, 1'b0, 1'b0, "os_down");
        cyc(8'd0, 1'b1, 1'b1, "os_done");
        for (int i = 0; i < 10; i++) cyc(8'd0, 1'b0, 1'b1, "os_frozen");
        bus.load     = 1'b1;
        bus.load_val = 8'd5;
        cyc(8'd5, 1'b0, 1'b0, "os_reload");
        bus.load = 1'b0;
        cyc(8'd4, 1'b0, 1'b0, "os_resume1");
        cyc(8'd3, 1'b0, 1'b0, "os_resume2");

        // Load clamp wins over ena, then wrap at the limit
        bus.mode     = 2'b00;
        bus.up       = 1'b1;
        bus.max_val  = 8'd100;
        bus.load     = 1'b1;
        bus.load_val = 8'd200;
        cyc(8'd100, 1'b0, 1'b0, "load_clamp");
        bus.load = 1'b0;
        cyc(8'd0, 1'b0, 1'b0, "wrap_at_max");

        // Limit lowered below result in wrap-up
        bus.load     = 1'b1;
        bus.load_val = 8'd50;
        cyc(8'd50, 1'b0, 1'b0, "lim_load");
        bus.load    = 1'b0;
        bus.max_val = 8'd20;
        cyc(8'd0, 1'b0, 1'b0, "lim_drop");
        for (int i = 1; i <= 19; i++) cyc(8'(i), 1'b0, 1'b0, "lim_count");
        cyc(8'd20, 1'b1, 1'b0, "lim_tc");
        cyc(8'd0, 1'b0, 1'b0, "lim_wrap");

        // Mode 11 behaves as saturate
        bus.mode     = 2'b11;
        bus.up       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 8'd1;
        cyc(8'd1, 1'b0, 1'b0, "m3_load");
        bus.load = 1'b0;
        cyc(8'd0, 1'b1, 1'b0, "m3_tc");
        cyc(8'd0, 1'b0, 1'b0, "m3_hold");

        bus.ena = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
